// File: rtl/pipeline_stall_sequencer.sv
// Stall/flush sequencer: merges hazard-unit requests with data-memory waits.
// Optional perf counters are enabled by defining PIPE_STALL_PERF_EN.
module pipeline_stall_sequencer #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             load_use_i,
  input  logic             flush_req_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_write_o,
  output logic             id_ex_bubble_o,
  output logic             ex_mem_write_o,
  output logic             mem_wb_bubble_o,
  output logic             busy_o,
  output logic             error_o,
  output logic [CNT_W-1:0] mem_stall_cnt_o,
  output logic [CNT_W-1:0] load_use_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_TO  = CNT_W'(TIMEOUT);
  localparam bit               LP_WD  = (TIMEOUT != 0);

  state_t           r_state;
  logic [CNT_W-1:0] r_wait_cnt;

  logic w_run;
  logic w_wait;
  logic w_miss;
  logic w_go;
  logic w_lu;
  logic w_fl;
  logic w_cnt_max;
  logic w_timeout;

  // A RUN-state access that is not ready freezes everything this cycle.
  assign w_run  = (r_state == S_RUN);
  assign w_wait = (r_state == S_WAIT);
  assign w_miss = w_run & dmem_req_i & ~dmem_ready_i;

  // Pipeline advances in RUN without a miss, or on the release cycle.
  assign w_go = (w_run & ~w_miss) | (w_wait & dmem_ready_i);

  // Load-use wins over a flush: branch operands are not ready yet.
  assign w_lu = w_go & load_use_i;
  assign w_fl = w_go & ~load_use_i & flush_req_i;

  assign w_cnt_max = &r_wait_cnt;
  assign w_timeout = LP_WD && (r_wait_cnt == LP_TO);

  assign pc_write_o      = w_go & ~load_use_i;
  assign if_id_write_o   = w_go & ~load_use_i;
  assign if_id_flush_o   = w_fl;
  assign id_ex_write_o   = w_go;
  assign id_ex_bubble_o  = w_lu;
  assign ex_mem_write_o  = w_go;
  assign mem_wb_bubble_o = ~w_go;
  assign busy_o          = w_wait;
  assign error_o         = (r_state == S_ERR);

  // Sequencer state and memory-wait watchdog counter.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_miss) begin
            r_state    <= S_WAIT;
            r_wait_cnt <= LP_ONE;
          end
        end
        S_WAIT: begin
          if (dmem_ready_i) begin
            r_state    <= S_RUN;
            r_wait_cnt <= '0;
          end else begin
            if (w_timeout) begin
              r_state <= S_ERR;
            end
            if (!w_cnt_max) begin
              r_wait_cnt <= r_wait_cnt + LP_ONE;
            end
          end
        end
        S_ERR: begin
          r_state <= S_ERR;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PIPE_STALL_PERF_EN
  logic             w_ms;
  logic [CNT_W-1:0] r_ms_cnt;
  logic [CNT_W-1:0] r_lu_cnt;
  logic [CNT_W-1:0] r_fl_cnt;

  assign w_ms = w_wait & ~dmem_ready_i;

  // Saturating per-cycle event counters.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_ms_cnt <= '0;
      r_lu_cnt <= '0;
      r_fl_cnt <= '0;
    end else begin
      if (w_ms && !(&r_ms_cnt)) begin
        r_ms_cnt <= r_ms_cnt + LP_ONE;
      end
      if (w_lu && !(&r_lu_cnt)) begin
        r_lu_cnt <= r_lu_cnt + LP_ONE;
      end
      if (w_fl && !(&r_fl_cnt)) begin
        r_fl_cnt <= r_fl_cnt + LP_ONE;
      end
    end
  end

  assign mem_stall_cnt_o = r_ms_cnt;
  assign load_use_cnt_o  = r_lu_cnt;
  assign flush_cnt_o     = r_fl_cnt;
`else
  assign mem_stall_cnt_o = '0;
  assign load_use_cnt_o  = '0;
  assign flush_cnt_o     = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Bench for pipeline_stall_sequencer: vector table, corner sequences,
// and random stimulus against a spec-level model (TIMEOUT 64 and 4).
module tb_pipeline_stall_sequencer;

  logic clk;
  logic rst_i, start_i, load_use_i, flush_req_i;
  logic dmem_req_i, dmem_ready_i;

  logic [8:0]  out0, out4;
  logic [31:0] ms0, lu0, fl0, ms4, lu4, fl4;

  int tests;
  int fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipeline_stall_sequencer u_dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .load_use_i(load_use_i), .flush_req_i(flush_req_i),
    .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i),
    .pc_write_o(out0[8]), .if_id_write_o(out0[7]),
    .if_id_flush_o(out0[6]), .id_ex_write_o(out0[5]),
    .id_ex_bubble_o(out0[4]), .ex_mem_write_o(out0[3]),
    .mem_wb_bubble_o(out0[2]), .busy_o(out0[1]),
    .error_o(out0[0]), .mem_stall_cnt_o(ms0),
    .load_use_cnt_o(lu0), .flush_cnt_o(fl0)
  );

  pipeline_stall_sequencer #(.TIMEOUT(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .load_use_i(load_use_i), .flush_req_i(flush_req_i),
    .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i),
    .pc_write_o(out4[8]), .if_id_write_o(out4[7]),
    .if_id_flush_o(out4[6]), .id_ex_write_o(out4[5]),
    .id_ex_bubble_o(out4[4]), .ex_mem_write_o(out4[3]),
    .mem_wb_bubble_o(out4[2]), .busy_o(out4[1]),
    .error_o(out4[0]), .mem_stall_cnt_o(ms4),
    .load_use_cnt_o(lu4), .flush_cnt_o(fl4)
  );

  // Output vector: pc,ifw,iffl,idw,idbub,exw,wbbub,busy,err
  localparam logic [8:0] FRZ  = 9'h004;
  localparam logic [8:0] WFRZ = 9'h006;
  localparam logic [8:0] EFRZ = 9'h005;
  localparam logic [8:0] NORM = 9'h1A8;
  localparam logic [8:0] LUO  = 9'h038;
  localparam logic [8:0] FLO  = 9'h1E8;

  // Model: mode 0 idle, 1 run, 2 waiting, 3 error
  int     m_mode [2];
  int     m_wait [2];
  longint m_ms   [2];
  longint m_lu   [2];
  longint m_fl   [2];
  int     m_to   [2];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0;
      m_wait[k] = 0;
      m_ms[k] = 0;
      m_lu[k] = 0;
      m_fl[k] = 0;
    end
  endtask

  task automatic step(input logic rs, input logic st, input logic lu,
                      input logic fl, input logic rq, input logic rd);
    logic [8:0]  exp, got;
    logic [31:0] gms, glu, gfl;
    bit          adv;
    @(negedge clk);
    rst_i = rs; start_i = st; load_use_i = lu;
    flush_req_i = fl; dmem_req_i = rq; dmem_ready_i = rd;
    #1;
    for (int k = 0; k < 2; k++) begin
      got = (k == 0) ? out0 : out4;
      gms = (k == 0) ? ms0 : ms4;
      glu = (k == 0) ? lu0 : lu4;
      gfl = (k == 0) ? fl0 : fl4;
`ifdef PIPE_STALL_PERF_EN
      chk($sformatf("ms_cnt d%0d", k), gms, 32'(m_ms[k]));
      chk($sformatf("lu_cnt d%0d", k), glu, 32'(m_lu[k]));
      chk($sformatf("fl_cnt d%0d", k), gfl, 32'(m_fl[k]));
`else
      chk($sformatf("ms_cnt d%0d", k), gms, 32'd0);
      chk($sformatf("lu_cnt d%0d", k), glu, 32'd0);
      chk($sformatf("fl_cnt d%0d", k), gfl, 32'd0);
`endif
      exp = FRZ;
      adv = 0;
      case (m_mode[k])
        0: if (st) m_mode[k] = 1;
        1: begin
          if (rq && !rd) begin
            m_mode[k] = 2;
            m_wait[k] = 1;
          end else begin
            adv = 1;
          end
        end
        2: begin
          if (rd) begin
            adv = 1;
            m_mode[k] = 1;
            m_wait[k] = 0;
          end else begin
            m_ms[k]++;
            if (m_to[k] != 0 && m_wait[k] == m_to[k]) m_mode[k] = 3;
            m_wait[k]++;
          end
          exp[1] = 1'b1;
        end
        default: exp[0] = 1'b1;
      endcase
      if (adv) begin
        if (lu) begin
          exp = LUO | (exp & 9'h002);
          m_lu[k]++;
        end else if (fl) begin
          exp = FLO | (exp & 9'h002);
          m_fl[k]++;
        end else begin
          exp = NORM | (exp & 9'h002);
        end
      end
      chk($sformatf("outs d%0d", k), {23'd0, got}, {23'd0, exp});
      if (!rs) begin
        m_mode[k] = 0;
        m_wait[k] = 0;
        m_ms[k] = 0;
        m_lu[k] = 0;
        m_fl[k] = 0;
      end
    end
  endtask

  typedef struct {
    string      nm;
    logic [5:0] in;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string nm, input logic [5:0] in,
                              input logic [8:0] exp);
    vec_t v;
    v.nm = nm;
    v.in = in;
    v.exp = exp;
    return v;
  endfunction

  initial begin
    logic [5:0] iv;
    tests = 0;
    fails = 0;
    m_to[0] = 64;
    m_to[1] = 4;
    model_reset();
    rst_i = 0; start_i = 0; load_use_i = 0;
    flush_req_i = 0; dmem_req_i = 0; dmem_ready_i = 0;
    repeat (2) @(posedge clk);

    // in = {rst, start, lu, fl, req, rdy}
    tbl.push_back(mk("reset",       6'b000000, FRZ));
    tbl.push_back(mk("idle_start",  6'b110000, FRZ));
    tbl.push_back(mk("run_norm",    6'b100000, NORM));
    tbl.push_back(mk("run_norm2",   6'b100000, NORM));
    tbl.push_back(mk("lu_over_fl",  6'b101100, LUO));
    tbl.push_back(mk("flush",       6'b100100, FLO));
    tbl.push_back(mk("mem_hit",     6'b100011, NORM));
    tbl.push_back(mk("mem_miss",    6'b100010, FRZ));
    tbl.push_back(mk("wait1",       6'b100010, WFRZ));
    tbl.push_back(mk("wait2",       6'b100010, WFRZ));
    tbl.push_back(mk("wait3",       6'b100010, WFRZ));
    tbl.push_back(mk("release",     6'b100011, NORM | 9'h002));
    tbl.push_back(mk("after_rel",   6'b100000, NORM));
    tbl.push_back(mk("miss_lu",     6'b101010, FRZ));
    tbl.push_back(mk("wait_lu",     6'b101010, WFRZ));
    tbl.push_back(mk("rel_lu",      6'b101001, LUO | 9'h002));
    tbl.push_back(mk("start_ign",   6'b110000, NORM));
    tbl.push_back(mk("miss_b",      6'b100010, FRZ));
    tbl.push_back(mk("wait_b1",     6'b100010, WFRZ));
    tbl.push_back(mk("wait_b2_rst", 6'b000010, WFRZ));
    tbl.push_back(mk("post_rst",    6'b100011, FRZ));

    foreach (tbl[i]) begin
      iv = tbl[i].in;
      step(iv[5], iv[4], iv[3], iv[2], iv[1], iv[0]);
      chk(tbl[i].nm, {23'd0, out0}, {23'd0, tbl[i].exp});
    end

    // load-use and flush together: only load-use counted
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
`ifdef PIPE_STALL_PERF_EN
    chk("lu_cnt_after", lu0, 32'd1);
    chk("fl_cnt_after", fl0, 32'd0);
`else
    chk("lu_cnt_tied", lu0, 32'd0);
    chk("fl_cnt_tied", fl0, 32'd0);
`endif

    // three stalled MEM_WAIT cycles then release
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 1, 0);
      chk("busy_wait", {31'd0, out0[1]}, 32'd1);
    end
    step(1, 0, 0, 0, 1, 1);
    chk("rel_exmem_w", {31'd0, out0[3]}, 32'd1);
    chk("rel_wb_bub", {31'd0, out0[2]}, 32'd0);
    step(1, 0, 0, 0, 0, 0);
`ifdef PIPE_STALL_PERF_EN
    chk("ms_cnt_3", ms0, 32'd3);
`else
    chk("ms_cnt_tied", ms0, 32'd0);
`endif

    // watchdog on the TIMEOUT=4 instance
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 1, 0);
      chk("no_err_yet", {31'd0, out4[0]}, 32'd0);
    end
    step(1, 0, 0, 0, 1, 0);
    chk("err_set", {23'd0, out4}, {23'd0, EFRZ});
    chk("d64_still_wait", {23'd0, out0}, {23'd0, WFRZ});
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 1, 1);
      chk("err_sticky", {23'd0, out4}, {23'd0, EFRZ});
    end
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("err_cleared", {23'd0, out4}, {23'd0, FRZ});

    // random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(49) != 0), ($urandom_range(7) == 0),
           ($urandom_range(3) == 0), ($urandom_range(3) == 0),
           ($urandom_range(2) == 0), ($urandom_range(3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_sequencer.md
Name: pipeline_stall_sequencer

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Merges the load-use stall and the branch flush from the hazard detection unit with multi-cycle data-memory waits.
- Drives the per-stage write, bubble and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Owns the memory-wait FSM and a watchdog that traps a hung memory.

Parameters:
- TIMEOUT, 64: max consecutive MEM_WAIT cycles before ERROR; 0 disables the watchdog.
- CNT_W, 32: width of the wait counter and perf counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-low reset
- start_i  in  1  leave IDLE and begin execution (level, sampled each cycle)
- load_use_i  in  1  load-use stall request from the hazard unit
- flush_req_i  in  1  taken branch resolved in ID
- dmem_req_i  in  1  EX/MEM holds MemRead or MemWrite this cycle
- dmem_ready_i  in  1  data memory completes the access this cycle
- pc_write_o  out  1  PC update enable
- if_id_write_o  out  1  IF/ID register enable
- if_id_flush_o  out  1  zero IF/ID instruction
- id_ex_write_o  out  1  ID/EX register enable
- id_ex_bubble_o  out  1  force ID/EX control bits to 0
- ex_mem_write_o  out  1  EX/MEM register enable
- mem_wb_bubble_o  out  1  force MEM/WB control bits to 0
- busy_o  out  1  state is MEM_WAIT
- error_o  out  1  state is ERROR
- mem_stall_cnt_o  out  CNT_W  perf counter
- load_use_cnt_o  out  CNT_W  perf counter
- flush_cnt_o  out  CNT_W  perf counter

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low on rst_i.
- Reset (rst_i=0 at a rising edge): state=IDLE, wait counter=0, perf counters=0.
- States: IDLE, RUN, MEM_WAIT, ERROR. State is registered. Outputs are combinational from state and current inputs, so there is zero-cycle latency from a request to its control.
- "All-freeze" means:
  - pc_write, if_id_write, id_ex_write, ex_mem_write = 0
  - id_ex_bubble = 0, if_id_flush = 0
  - mem_wb_bubble = 1
- IDLE:
  - Outputs are all-freeze.
  - start_i=1 -> RUN next cycle.
- RUN, evaluated in priority order:
  1. dmem_req_i=1 and dmem_ready_i=0: outputs all-freeze. -> MEM_WAIT; wait counter <= 1.
  2. load_use_i=1: pc_write=0, if_id_write=0, id_ex_bubble=1; all other enables 1. flush_req_i is ignored this cycle, because branch operands are not ready.
  3. flush_req_i=1: all enables 1, if_id_flush=1.
  4. Otherwise: all enables 1, bubbles and flush 0.
- A memory access with dmem_ready_i=1 in the same cycle as dmem_req_i completes with no stall.
- MEM_WAIT:
  - dmem_ready_i=0: outputs all-freeze; wait counter increments.
  - If TIMEOUT!=0 and the counter equals TIMEOUT -> ERROR.
  - dmem_ready_i=1: behave as RUN cases 2-4, with the memory access considered done (MEM/WB captures the data). -> RUN; wait counter <= 0.
  - load_use_i and flush_req_i arriving while waiting are held by the frozen pipeline and act on the release cycle.
- ERROR:
  - Outputs are all-freeze; error_o=1.
  - Sticky; exits only on reset.
- start_i is ignored outside IDLE.
- Reset mid-MEM_WAIT -> IDLE with no release cycle.
- The wait counter saturates at all-ones when TIMEOUT=0.

Optional Feature:
- Macro: PIPE_STALL_PERF_EN.
- When defined, counting is per clock cycle:
  - mem_stall_cnt_o counts cycles with state=MEM_WAIT and dmem_ready_i=0.
  - load_use_cnt_o counts cycles where RUN case 2 is applied.
  - flush_cnt_o counts cycles with if_id_flush_o=1.
  - All three saturate at 2^CNT_W-1 and clear on reset.
- When undefined: all three outputs are tied to 0 and no counter flops are inferred. Ports remain.

Test Plan:
- Reset, then start_i=1 for 1 cycle, no requests -> cycle 1 IDLE all-freeze; from cycle 2 all enables=1, bubbles=0, busy_o=0.
- load_use_i=1 and flush_req_i=1 in the same RUN cycle:
  - required: pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1, if_id_flush_o=0;
  - with PIPE_STALL_PERF_EN defined: load_use_cnt_o=1, flush_cnt_o=0.
- dmem_req_i=1, dmem_ready_i=0 for 3 cycles, then ready=1:
  - busy_o=1 for 3 cycles with all-freeze;
  - release cycle has ex_mem_write_o=1, mem_wb_bubble_o=0;
  - mem_stall_cnt_o=3 when the perf macro is defined.
- TIMEOUT=4, dmem_ready_i held 0 -> error_o=1 after 4 wait cycles and stays 1 despite a later ready=1; rst_i=0 returns to IDLE with error_o=0.
- Assert rst_i=0 during the 2nd MEM_WAIT cycle -> next cycle state IDLE, busy_o=0, all counters 0, no release-cycle enables.
